// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: requester, bulk-clear and register-file write signals of the write arbiter.
// Parameters: NREQ requesters, AW address bits, DW data bits.
// Signals:
//   req/req_addr/req_data  requester write requests, packed per requester
//   gnt                    one-hot combinational accept back to the requesters
//   clr_start              one-cycle pulse that starts a bulk clear
//   clr_done/busy          bulk-clear completion pulse and in-progress flag
//   rf_we/rf_waddr/rf_wdata registered write port of the register file
// Modports: master (requesters, clear controller and register file), slave (the arbiter).
interface regfile_write_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic               clr_start;
    logic               clr_done;
    logic               busy;
    logic               rf_we;
    logic [AW-1:0]      rf_waddr;
    logic [DW-1:0]      rf_wdata;
    modport master (
        output req, req_addr, req_data, clr_start,
        input  gnt, clr_done, busy, rf_we, rf_waddr, rf_wdata
    );
    modport slave (
        input  req, req_addr, req_data, clr_start,
        output gnt, clr_done, busy, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register-file write port plus a bulk-clear sequencer.
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   bus           regfile_write_arbiter_if.slave (requests, grants, clear control, rf write port)
//   i_stat_sel    (ARB_STATS_EN only) requester whose grant count is shown
//   o_stat_count  (ARB_STATS_EN only) saturating grant count of requester i_stat_sel
// Optional feature macro: ARB_STATS_EN adds per-requester grant counters.
module regfile_write_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 8
) (
    input  logic clk,
    input  logic reset,
`ifdef ARB_STATS_EN
    input  logic [(NREQ > 1 ? $clog2(NREQ) : 1)-1:0] i_stat_sel,
    output logic [15:0]                              o_stat_count,
`endif
    regfile_write_arbiter_if.slave bus
);
    localparam int DEPTH = 2 ** AW;
    localparam int PW    = NREQ > 1 ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          r_state, w_state_next;
    logic [PW-1:0]   r_ptr, w_ptr_next, w_gidx;
    logic [AW-1:0]   r_cnt, w_cnt_next, r_waddr, w_waddr_next;
    logic [DW-1:0]   r_wdata, w_wdata_next;
    logic            r_we, w_we_next, r_done, w_done_next, w_found;
    logic [NREQ-1:0] w_gnt;

    // Round-robin search: requesters at or above the pointer first, then the wrapped-around ones.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && bus.req[i] && PW'(i) >= r_ptr) begin
                w_found = 1'b1;
                w_gidx  = PW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && bus.req[i] && PW'(i) < r_ptr) begin
                w_found = 1'b1;
                w_gidx  = PW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_cnt   <= w_cnt_next;
            r_we    <= w_we_next;
            r_waddr <= w_waddr_next;
            r_wdata <= w_wdata_next;
            r_done  <= w_done_next;
        end
    end

    // gnt depends only on req, state, clr_start and the pointer; clr_start pre-empts arbitration.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_cnt_next   = r_cnt;
        w_we_next    = 1'b0;
        w_waddr_next = r_waddr;
        w_wdata_next = r_wdata;
        w_done_next  = 1'b0;
        w_gnt        = '0;
        if (r_state == CLEAR) begin
            w_we_next    = 1'b1;
            w_waddr_next = r_cnt;
            w_wdata_next = '0;
            w_cnt_next   = r_cnt + AW'(1);
            if (r_cnt == AW'(DEPTH - 1)) begin
                w_state_next = IDLE;
                w_done_next  = 1'b1;
            end
        end else if (bus.clr_start) begin
            w_state_next = CLEAR;
            w_cnt_next   = '0;
        end else if (w_found) begin
            w_gnt        = NREQ'(1) << w_gidx;
            w_we_next    = 1'b1;
            w_waddr_next = bus.req_addr[int'(w_gidx) * AW +: AW];
            w_wdata_next = bus.req_data[int'(w_gidx) * DW +: DW];
            w_ptr_next   = (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + PW'(1);
        end
    end

    assign bus.gnt      = w_gnt;
    assign bus.busy     = (r_state == CLEAR);
    assign bus.clr_done = r_done;
    assign bus.rf_we    = r_we;
    assign bus.rf_waddr = r_waddr;
    assign bus.rf_wdata = r_wdata;

`ifdef ARB_STATS_EN
    logic [15:0] r_stat [NREQ];

    // Grant counters survive a bulk clear; only reset zeroes them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (reset)
                r_stat[i] <= '0;
            else if (w_gnt[i] && r_stat[i] != 16'hFFFF)
                r_stat[i] <= r_stat[i] + 16'd1;
        end
    end

    assign o_stat_count = (int'(i_stat_sel) < NREQ) ? r_stat[i_stat_sel] : '0;
`endif
endmodule
